// File: rtl/seven_seg_sniffer.sv
// Receive-side monitor for a 4-digit multiplexed active-low seven-segment bus: rebuilds the shown hex digits,
// flags illegal anode patterns and stalled scanning. Optional frame counter enabled by SEVSEG_FRAME_CNT_EN.
module seven_seg_sniffer #(
   parameter int STABLE_CYCLES = 16,
   parameter int STALL_CYCLES  = 200000
) (
   input  logic       clk_25MHz,
   input  logic       reset_n,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   output logic [3:0] digitA,
   output logic [3:0] digitB,
   output logic [3:0] digitC,
   output logic [3:0] digitD,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       anode_err,
   output logic       stalled
`ifdef SEVSEG_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int              CW          = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [17:0]     STALL_MAX   = 18'(STALL_CYCLES);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Returns {legal, value}; anything outside the sixteen hex glyphs is reported illegal.
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = {1'b1, 4'h0};
         7'h79:   r = {1'b1, 4'h1};
         7'h24:   r = {1'b1, 4'h2};
         7'h30:   r = {1'b1, 4'h3};
         7'h19:   r = {1'b1, 4'h4};
         7'h12:   r = {1'b1, 4'h5};
         7'h02:   r = {1'b1, 4'h6};
         7'h78:   r = {1'b1, 4'h7};
         7'h00:   r = {1'b1, 4'h8};
         7'h10:   r = {1'b1, 4'h9};
         7'h08:   r = {1'b1, 4'hA};
         7'h03:   r = {1'b1, 4'hB};
         7'h46:   r = {1'b1, 4'hC};
         7'h21:   r = {1'b1, 4'hD};
         7'h06:   r = {1'b1, 4'hE};
         7'h0E:   r = {1'b1, 4'hF};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   logic [10:0]   sync1_r;
   logic [10:0]   sync2_r;
   logic [10:0]   prev_r;
   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_s;
   logic          changed_s;
   logic [3:0]    an_low_s;
   logic          capture_s;
   logic          err_set_s;
   logic [4:0]    glyph_s;
   logic [3:0]    mask_r;
   logic [3:0]    mask_next_s;
   logic [3:0]    digit_r [4];
   logic [3:0]    valid_r;
   logic          frame_done_r;
   logic          anode_err_r;
   logic [17:0]   stall_cnt_r;
   logic [17:0]   stall_next_s;
   logic          stalled_r;

   assign changed_s   = (sync2_r != prev_r);
   assign an_low_s    = ~sync2_r[10:7];
   assign glyph_s     = decode_glyph(sync2_r[6:0]);
   assign mask_next_s = mask_r | an_low_s;

   assign digitD      = digit_r[0];
   assign digitC      = digit_r[1];
   assign digitB      = digit_r[2];
   assign digitA      = digit_r[3];
   assign digit_valid = valid_r;
   assign frame_done  = frame_done_r;
   assign anode_err   = anode_err_r;
   assign stalled     = stalled_r;

   // Input synchronizer, previous-sample register and FSM state.
   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         sync1_r <= 11'h7FF;
         sync2_r <= 11'h7FF;
         prev_r  <= 11'h7FF;
         state_r <= ST_WAIT;
         count_r <= '0;
      end else begin
         sync1_r <= {an, seg};
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         state_r <= state_s;
         count_r <= count_s;
      end
   end

   // Next-state logic: a pattern is acted on once it has stayed unchanged long enough.
   always_comb begin
      state_s   = state_r;
      count_s   = count_r;
      capture_s = 1'b0;
      err_set_s = 1'b0;
      case (state_r)
         ST_WAIT: begin
            if (changed_s) begin
               state_s = ST_SETTLE;
               count_s = '0;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_SETTLE: begin
            if (changed_s) begin
               count_s = '0;
            end else if (count_r == SETTLE_LAST) begin
               count_s = '0;
               if ($onehot(an_low_s)) begin
                  capture_s = 1'b1;
                  state_s   = ST_HOLD;
               end else if (an_low_s == 4'h0) begin
                  state_s = ST_WAIT;
               end else begin
                  err_set_s = 1'b1;
                  state_s   = ST_HOLD;
               end
            end else begin
               count_s = count_r + 1'b1;
            end
         end
         ST_HOLD: begin
            if (changed_s) begin
               state_s = ST_SETTLE;
               count_s = '0;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_WAIT;
            count_s = '0;
         end
      endcase
   end

   // Digit capture, capture mask, frame pulse and sticky anode error.
   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            digit_r[i] <= 4'h0;
         end
         valid_r      <= 4'h0;
         mask_r       <= 4'h0;
         frame_done_r <= 1'b0;
         anode_err_r  <= 1'b0;
      end else begin
         frame_done_r <= 1'b0;
         if (capture_s) begin
            for (int i = 0; i < 4; i++) begin
               if (an_low_s[i]) begin
                  if (glyph_s[4]) begin
                     digit_r[i] <= glyph_s[3:0];
                     valid_r[i] <= 1'b1;
                  end else begin
                     valid_r[i] <= 1'b0;
                  end
               end
            end
            if (mask_next_s == 4'hF) begin
               mask_r       <= 4'h0;
               frame_done_r <= 1'b1;
            end else begin
               mask_r <= mask_next_s;
            end
         end
         if (err_set_s) begin
            anode_err_r <= 1'b1;
         end
      end
   end

   // A capture clears the stall counter in the same cycle it would saturate, so capture wins.
   always_comb begin
      if (capture_s) begin
         stall_next_s = 18'd0;
      end else if (stall_cnt_r == STALL_MAX) begin
         stall_next_s = stall_cnt_r;
      end else begin
         stall_next_s = stall_cnt_r + 18'd1;
      end
   end

   // Stall counter and stalled flag.
   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         stall_cnt_r <= 18'd0;
         stalled_r   <= 1'b0;
      end else begin
         stall_cnt_r <= stall_next_s;
         stalled_r   <= (stall_next_s == STALL_MAX);
      end
   end

`ifdef SEVSEG_FRAME_CNT_EN
   logic [15:0] frame_count_r;

   assign frame_count = frame_count_r;

   // Free-running count of completed frames, wrapping at 16 bits.
   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         frame_count_r <= 16'h0000;
      end else if (frame_done_r) begin
         frame_count_r <= frame_count_r + 16'h0001;
      end else begin
         frame_count_r <= frame_count_r;
      end
   end
`endif

endmodule

// File: tb/tb_seven_seg_sniffer.sv
// Randomized scoreboard bench for seven_seg_sniffer: a pattern-level model predicts each completed frame.
module tb_seven_seg_sniffer;

   localparam int STABLE     = 16;
   localparam int STALL      = 3000;
   localparam int LONG_MIN   = 20;
   localparam int LONG_MAX   = 60;
   localparam int GLITCH_MAX = 10;

   logic        clk_25MHz = 1'b0;
   logic        reset_n   = 1'b0;
   logic [3:0]  an        = 4'hF;
   logic [6:0]  seg       = 7'h7F;
   logic [3:0]  digitA, digitB, digitC, digitD, digit_valid;
   logic        frame_done, anode_err, stalled;
`ifdef SEVSEG_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   always #20 clk_25MHz = ~clk_25MHz;

   seven_seg_sniffer #(.STABLE_CYCLES(STABLE), .STALL_CYCLES(STALL)) dut (
      .clk_25MHz   (clk_25MHz),
      .reset_n     (reset_n),
      .an          (an),
      .seg         (seg),
      .digitA      (digitA),
      .digitB      (digitB),
      .digitC      (digitC),
      .digitD      (digitD),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .anode_err   (anode_err),
      .stalled     (stalled)
`ifdef SEVSEG_FRAME_CNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  valid;
      logic        err;
   } snap_t;

   logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0]  m_digit [4];
   logic [3:0]  m_valid, m_mask;
   logic        m_err;
   logic [10:0] last_pat;
   snap_t       sb_q [$];
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lookup(input logic [6:0] s);
      for (int i = 0; i < 16; i++) begin
         if (glyph_tab[i] == s) return i;
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
      m_valid  = 4'h0;
      m_mask   = 4'h0;
      m_err    = 1'b0;
      last_pat = 11'h7FF;
   endtask

   // Effect of one pattern held long enough to be recognised.
   task automatic model_event(input logic [3:0] a, input logic [6:0] s);
      int lows;
      int pos;
      int g;
      lows = $countones(~a);
      pos  = 0;
      if (lows == 1) begin
         for (int i = 0; i < 4; i++) if (!a[i]) pos = i;
         g = lookup(s);
         if (g >= 0) begin
            m_digit[pos] = 4'(g);
            m_valid[pos] = 1'b1;
         end else begin
            m_valid[pos] = 1'b0;
         end
         m_mask[pos] = 1'b1;
         if (m_mask == 4'hF) begin
            sb_q.push_back('{digits: {m_digit[3], m_digit[2], m_digit[1], m_digit[0]},
                             valid: m_valid, err: m_err});
            m_mask = 4'h0;
         end
      end else if (lows > 1) begin
         m_err = 1'b1;
      end
   endtask

   task automatic run(input logic [3:0] a, input logic [6:0] s, input int len);
      an  = a;
      seg = s;
      if (len >= LONG_MIN) model_event(a, s);
      last_pat = {a, s};
      repeat (len) @(negedge clk_25MHz);
   endtask

   task automatic rand_run();
      logic [3:0] a;
      logic [6:0] s;
      int r;
      int len;
      do begin
         r   = $urandom_range(0, 99);
         len = $urandom_range(LONG_MIN, LONG_MAX);
         if (r < 62) begin
            a = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) s = 7'($urandom);
            else s = glyph_tab[$urandom_range(0, 15)];
         end else if (r < 72) begin
            a = 4'hF;
            s = 7'($urandom);
         end else if (r < 75) begin
            do a = 4'($urandom); while ($countones(~a) < 2);
            s = glyph_tab[$urandom_range(0, 15)];
         end else begin
            a   = 4'($urandom);
            s   = 7'($urandom);
            len = $urandom_range(1, GLITCH_MAX);
         end
      end while ({a, s} == last_pat);
      run(a, s, len);
   endtask

   task automatic check_reset_state();
      check("rst_digits", 32'({digitA, digitB, digitC, digitD}), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      check("rst_anode_err", 32'(anode_err), 32'h0);
      check("rst_stalled", 32'(stalled), 32'h0);
   endtask

   task automatic do_reset();
      check("sb_empty_before_reset", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
      reset_n = 1'b0;
      an      = 4'hF;
      seg     = 7'h7F;
      repeat (2) @(negedge clk_25MHz);
      check_reset_state();
      reset_n = 1'b1;
      model_clear();
   endtask

   // Scoreboard monitor: every frame pulse must match the oldest predicted frame.
   always @(negedge clk_25MHz) begin
      snap_t e;
      if (reset_n && frame_done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_frame_done", 32'h1, 32'h0);
         end else begin
            e = sb_q.pop_front();
            check("frame_digits", 32'({digitA, digitB, digitC, digitD}), 32'(e.digits));
            check("frame_valid", 32'(digit_valid), 32'(e.valid));
            check("frame_anode_err", 32'(anode_err), 32'(e.err));
         end
      end
   end

   initial begin
      model_clear();
      @(negedge clk_25MHz);
      do_reset();

      // Clean scan D=1, C=2, B=3, A=4, two frames, plus a short glitch inside a slot.
      for (int f = 0; f < 2; f++) begin
         run(4'b1110, glyph_tab[1], 40);
         run(4'b1101, glyph_tab[2], 40);
         run(4'b1101, glyph_tab[7], 5);
         run(4'b1101, glyph_tab[2], 40);
         run(4'b1011, glyph_tab[3], 40);
         run(4'b0111, glyph_tab[4], 40);
      end
      check("scan_digits", 32'({digitA, digitB, digitC, digitD}), 32'h4321);

      // Blank glyph on position D keeps the old digit but marks it invalid.
      run(4'b1110, 7'h7F, 40);
      check("blank_valid", 32'(digit_valid), 32'hE);
      check("blank_digitD", 32'(digitD), 32'h1);

      repeat (300) rand_run();
      repeat (30) @(negedge clk_25MHz);
      check("phase1_valid", 32'(digit_valid), 32'(m_valid));
      check("phase1_digits", 32'({digitA, digitB, digitC, digitD}),
            32'({m_digit[3], m_digit[2], m_digit[1], m_digit[0]}));

      // Two anodes low: sticky error until reset.
      run(4'b1100, glyph_tab[8], 40);
      check("anode_err_set", 32'(anode_err), 32'h1);
      run(4'hF, 7'h7F, 40);
      run(4'b1110, glyph_tab[3], 40);
      check("anode_err_sticky", 32'(anode_err), 32'h1);

      // Partial frame then reset: the next frame needs four fresh captures.
      run(4'b1101, glyph_tab[6], 40);
      do_reset();
      repeat (200) rand_run();

      // Freeze on one slot until stalled, then resume.
      if (last_pat == {4'b1110, glyph_tab[5]}) run(4'hF, 7'h7F, 40);
      run(4'b1110, glyph_tab[5], 1500);
      check("stall_early", 32'(stalled), 32'h0);
      repeat (1700) @(negedge clk_25MHz);
      check("stall_set", 32'(stalled), 32'h1);
      an  = 4'b1101;
      seg = glyph_tab[9];
      model_event(4'b1101, glyph_tab[9]);
      repeat (STABLE + 1) @(negedge clk_25MHz);
      check("stall_before_capture", 32'(stalled), 32'h1);
      repeat (4) @(negedge clk_25MHz);
      check("stall_cleared", 32'(stalled), 32'h0);
      check("resume_digitC", 32'(digitC), 32'h9);
      repeat (30) @(negedge clk_25MHz);

      check("sb_empty_final", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
